rs232_mem_ctrl: RTL and testbench

//  Parametrised word memory behind a valid/ready request and response handshake, serving the RS232 command path.

---
 rtl/rs232_mem_pkg.sv | 27 ++
 rtl/rs232_mem_array.sv | 32 +++
 rtl/rs232_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rs232_mem_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_mem_pkg.sv
// Shared definitions for the RS232 command-path word memory: controller
// state encoding, default geometry and the parity helper used when the
// RS232_MEM_PARITY_EN build option stores a check bit with each word.
package rs232_mem_pkg;

  // Default geometry: one byte per word, 256 words.
  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 256;

  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int PARITY_MAX_W  = 64;

  // Controller states: clear sweep, wait for request, RAM access, hold response.
  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Even parity bit: makes the total count of ones (data + bit) even.
  // Zero-extension does not change the result.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rs232_mem_array.sv
// Single-port synchronous RAM: write-enable, shared address, and a
// registered read port with one cycle of latency. The read returns the
// word stored before any same-cycle write (read-first).
module rs232_mem_array
  import rs232_mem_pkg::*;
#(
  parameter  int W     = DW_DEFAULT,
  parameter  int DEPTH = DEPTH_DEFAULT,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage write and registered read, one access per cycle.
  // NOTE: the array and its read register have no reset; storage contents
  // are defined by the controller's clear sweep, and keeping reset off the
  // memory lets it map onto block RAM. Sequential state uses <= so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rs232_mem_ctrl.sv
// RS232 command-path memory controller. A valid/ready request port reads or
// writes one word of a parametrised RAM, either at an explicit address or at
// an auto-incrementing burst pointer. Each request yields exactly one
// response held until it is consumed. A clear engine sweeps CLR_VALUE into
// every word after reset and whenever clr_req is seen in IDLE. Addresses at
// or beyond DEPTH (possible only for non-power-of-2 depths) are flagged via
// rsp_err and never touch the RAM.
//
// Build option: define RS232_MEM_PARITY_EN to store an even-parity bit with
// each word; a read whose stored parity disagrees with its data reports
// rsp_err but still returns the stored data.
module rs232_mem_ctrl
  import rs232_mem_pkg::*;
#(
  parameter  int            DW        = DW_DEFAULT,
  parameter  int            DEPTH     = DEPTH_DEFAULT,
  parameter  logic [DW-1:0] CLR_VALUE = '0,
  localparam int            AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  // Request channel
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_inc,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  // Response channel
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  // Clear control
  input  logic          clr_req,
  output logic          clr_busy
);

`ifdef RS232_MEM_PARITY_EN
  localparam int RW = DW + 1;
`else
  localparam int RW = DW;
`endif

  // Last valid word address, and DEPTH widened by one bit so the range
  // compare also works when DEPTH is an exact power of 2.
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] clr_ptr;     // next word the clear sweep writes
  logic [AW-1:0] ptr;         // burst pointer used when req_inc=1
  logic          acc_write;   // accepted request was a write
  logic          acc_oor;     // accepted request was out of range

  logic [AW-1:0] ea;          // effective address of the presented request
  logic          ea_oor;
  logic          accept;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_wdata;
  logic [RW-1:0] ram_rdata;
  logic [RW-1:0] clr_word;
  logic [RW-1:0] req_word;
  logic [DW-1:0] rd_data;
  logic          rd_parity_err;

  assign ea        = req_inc ? ptr : req_addr;
  assign ea_oor    = {1'b0, ea} >= DEPTH_EXT;

  // A pending clear wins over a simultaneous request, so ready drops with it.
  assign req_ready = (state == ST_IDLE) && !clr_req;
  assign accept    = req_valid && req_ready;
  assign clr_busy  = (state == ST_CLEAR);

`ifdef RS232_MEM_PARITY_EN
  assign clr_word      = {even_parity(PARITY_MAX_W'(CLR_VALUE)), CLR_VALUE};
  assign req_word      = {even_parity(PARITY_MAX_W'(req_wdata)), req_wdata};
  assign rd_data       = ram_rdata[DW-1:0];
  assign rd_parity_err = ram_rdata[DW] != even_parity(PARITY_MAX_W'(rd_data));
`else
  assign clr_word      = CLR_VALUE;
  assign req_word      = req_wdata;
  assign rd_data       = ram_rdata;
  assign rd_parity_err = 1'b0;
`endif

  // RAM port mux: the clear sweep owns the port while clearing, otherwise
  // the request path drives it. Out-of-range addresses are parked at word 0
  // so the RAM never sees an index beyond DEPTH-1.
  // NOTE: every signal gets a default before the branches so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ea_oor ? '0 : ea;
    ram_wdata = req_word;
    if (state == ST_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_ptr;
      ram_wdata = clr_word;
    end else if (accept) begin
      ram_we    = req_write && !ea_oor;
    end
  end

  rs232_mem_array #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Controller FSM: clear sweep, request accept, read capture and response hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      clr_ptr   <= '0;
      ptr       <= '0;
      acc_write <= 1'b0;
      acc_oor   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // One word per cycle; the last word hands over to IDLE with the
          // burst pointer rewound.
          if (clr_ptr == LAST_ADDR) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
            ptr     <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end

        ST_IDLE: begin
          if (clr_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end else if (accept) begin
            state     <= ST_ACCESS;
            acc_write <= req_write;
            acc_oor   <= ea_oor;
            // Every access, explicit or not, seeds the next burst address.
            ptr       <= (ea_oor || (ea == LAST_ADDR)) ? '0 : ea + 1'b1;
          end
        end

        ST_ACCESS: begin
          // RAM read data is valid now; build the response from it.
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= (acc_write || acc_oor) ? '0 : rd_data;
          rsp_err   <= acc_oor || (!acc_write && rd_parity_err);
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_mem_ctrl.sv
// Self-checking bench for rs232_mem_ctrl. Two instances run side by side:
// a power-of-2 depth (256) and a non-power-of-2 depth (200) that exposes
// out-of-range addresses. Requests are issued from a driver; each accepted
// request pushes its expected response, computed from a plain array model,
// into a per-instance queue. A separate monitor pops and compares on every
// response handshake.
module tb_rs232_mem_ctrl;

  localparam int DW     = 8;
  localparam int DEPTH0 = 256;
  localparam int DEPTH1 = 200;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_write [2];
  logic          req_inc   [2];
  logic [7:0]    req_addr  [2];
  logic [DW-1:0] req_wdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_rdata [2];
  logic          rsp_err   [2];
  logic          clr_req   [2];
  logic          clr_busy  [2];

  always #5 clk = ~clk;

  rs232_mem_ctrl #(.DW(DW), .DEPTH(DEPTH0), .CLR_VALUE(8'h00)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_inc(req_inc[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .clr_req(clr_req[0]), .clr_busy(clr_busy[0])
  );

  rs232_mem_ctrl #(.DW(DW), .DEPTH(DEPTH1), .CLR_VALUE(8'h00)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_inc(req_inc[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .clr_req(clr_req[1]), .clr_busy(clr_busy[1])
  );

  // Reference model state
  int            depth [2] = '{DEPTH0, DEPTH1};
  logic [DW-1:0] model_mem [2][256];
  int            model_ptr [2];
  bit            inject_parity_err = 1'b0;
  exp_t          exp_q0 [$];
  exp_t          exp_q1 [$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 256; i++) model_mem[k][i] = '0;
    model_ptr[k] = 0;
  endtask

  // Behaviour of one accepted request in terms of addresses and words.
  task automatic model_access(input int k, input logic write, input logic inc,
                              input logic [7:0] addr, input logic [DW-1:0] wdata,
                              output exp_t e);
    int ea;
    ea = inc ? model_ptr[k] : int'(addr);
    if (ea >= depth[k]) begin
      e.rdata      = '0;
      e.err        = 1'b1;
      model_ptr[k] = 0;
    end else begin
      e.err   = inject_parity_err && !write;
      e.rdata = write ? '0 : model_mem[k][ea];
      if (write) model_mem[k][ea] = wdata;
      model_ptr[k] = (ea + 1) % depth[k];
    end
  endtask

  // Monitor: compare every consumed response against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        check("unexpected_rsp_d0", 32'(rsp_valid[0]), 0);
      end else begin
        e = exp_q0.pop_front();
        check("rdata_d0", 32'(rsp_rdata[0]), 32'(e.rdata));
        check("err_d0",   32'(rsp_err[0]),   32'(e.err));
      end
    end
    if (rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        check("unexpected_rsp_d1", 32'(rsp_valid[1]), 0);
      end else begin
        e = exp_q1.pop_front();
        check("rdata_d1", 32'(rsp_rdata[1]), 32'(e.rdata));
        check("err_d1",   32'(rsp_err[1]),   32'(e.err));
      end
    end
  end

  // Issue one request; called and returns just after a rising edge.
  task automatic do_req(input int k, input logic write, input logic inc,
                        input logic [7:0] addr, input logic [DW-1:0] wdata,
                        input int stall);
    exp_t e;
    int   waited;
    req_valid[k] = 1'b1;
    req_write[k] = write;
    req_inc[k]   = inc;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    rsp_ready[k] = (stall == 0);
    waited = 0;
    @(negedge clk);
    while (req_ready[k] !== 1'b1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (req_ready[k] !== 1'b1) begin
      check("accept_timeout", 32'(req_ready[k]), 1);
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      return;
    end
    model_access(k, write, inc, addr, wdata, e);
    if (k == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    @(negedge clk);
    check("rsp_early", 32'(rsp_valid[k]), 0);
    @(negedge clk);
    check("rsp_latency", 32'(rsp_valid[k]), 1);
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", 32'(rsp_valid[k]), 1);
      check("hold_rdata", 32'(rsp_rdata[k]), 32'(e.rdata));
      check("hold_ready", 32'(req_ready[k]), 0);
      @(posedge clk); #1;
    end
    rsp_ready[k] = 1'b1;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (rsp_valid[k] === 1'b1 && waited < 100);
    if (rsp_valid[k] !== 1'b0) check("rsp_drain_timeout", 32'(rsp_valid[k]), 0);
  endtask

  // Count the cycles each instance spends clearing.
  task automatic wait_clear(output int cnt0, output int cnt1);
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (clr_busy[0] === 1'b1) cnt0++;
      if (clr_busy[1] === 1'b1) cnt1++;
      if (clr_busy[0] === 1'b0 && clr_busy[1] === 1'b0) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int c1;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_inc[k] = 1'b0;
      req_addr[k]  = '0;   req_wdata[k] = '0;   rsp_ready[k] = 1'b1;
      clr_req[k]   = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_clr_busy",  32'(clr_busy[k]),  1);
      check("rst_req_ready", 32'(req_ready[k]), 0);
      check("rst_rsp_valid", 32'(rsp_valid[k]), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata[k]), 0);
      check("rst_rsp_err",   32'(rsp_err[k]),   0);
    end

    // Initial clear sweep length, then ready
    rst = 1'b0;
    wait_clear(c0, c1);
    check("clear_cycles_d0", c0, DEPTH0);
    check("clear_cycles_d1", c1, DEPTH1);
    check("ready_after_clear_d0", 32'(req_ready[0]), 1);
    check("ready_after_clear_d1", 32'(req_ready[1]), 1);
    model_clear(0);
    model_clear(1);

    // Cleared words read back as CLR_VALUE
    do_req(0, 1'b0, 1'b0, 8'd0,   8'h00, 0);
    do_req(0, 1'b0, 1'b0, 8'd128, 8'h00, 0);
    do_req(0, 1'b0, 1'b0, 8'd255, 8'h00, 0);
    do_req(1, 1'b0, 1'b0, 8'd199, 8'h00, 0);

    // Write then read back
    do_req(0, 1'b1, 1'b0, 8'h10, 8'hA5, 0);
    do_req(0, 1'b0, 1'b0, 8'h10, 8'h00, 0);

    // Burst writes wrap the pointer past the last word
    do_req(0, 1'b1, 1'b0, 8'd254, 8'hFF, 0);
    do_req(0, 1'b1, 1'b1, 8'd0,   8'h11, 0);
    do_req(0, 1'b1, 1'b1, 8'd77,  8'h22, 0);
    do_req(0, 1'b0, 1'b1, 8'd0,   8'h00, 0);
    do_req(0, 1'b0, 1'b0, 8'd255, 8'h00, 0);
    do_req(0, 1'b0, 1'b0, 8'd0,   8'h00, 0);

    // Response held under backpressure, then IDLE after the handshake
    do_req(0, 1'b0, 1'b0, 8'h10, 8'h00, 5);
    check("idle_after_resp", 32'(req_ready[0]), 1);

    // Out-of-range accesses on the 200-word instance
    do_req(1, 1'b1, 1'b0, 8'd5,   8'h5A, 0);
    do_req(1, 1'b0, 1'b0, 8'd210, 8'h00, 0);
    do_req(1, 1'b0, 1'b1, 8'd0,   8'h00, 0);
    do_req(1, 1'b1, 1'b0, 8'd250, 8'hEE, 0);
    do_req(1, 1'b1, 1'b1, 8'd0,   8'h33, 0);
    do_req(1, 1'b1, 1'b0, 8'd199, 8'h44, 0);
    do_req(1, 1'b0, 1'b1, 8'd0,   8'h00, 0);
    do_req(1, 1'b0, 1'b0, 8'd199, 8'h00, 0);

    // Randomised traffic on both instances
    for (int n = 0; n < 160; n++) begin
      int k;
      k = int'($urandom_range(0, 1));
      do_req(k, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
             8'($urandom_range(0, 255)), 8'($urandom), int'($urandom_range(0, 2)));
    end

`ifdef RS232_MEM_PARITY_EN
    // Corrupt one stored parity bit; the read must flag it but keep the data
    do_req(0, 1'b1, 1'b0, 8'd7, 8'h3C, 0);
    dut0.u_array.mem[7][DW] = ~dut0.u_array.mem[7][DW];
    inject_parity_err = 1'b1;
    do_req(0, 1'b0, 1'b0, 8'd7, 8'h00, 0);
    inject_parity_err = 1'b0;
`endif

    // Clear request beats a simultaneous request
    do_req(0, 1'b1, 1'b0, 8'd3, 8'h9C, 0);
    clr_req[0]   = 1'b1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_inc[0]   = 1'b0;
    req_addr[0]  = 8'd5;
    req_wdata[0] = 8'h77;
    @(negedge clk);
    check("clr_blocks_ready", 32'(req_ready[0]), 0);
    @(posedge clk); #1;
    clr_req[0]   = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("clr_started", 32'(clr_busy[0]), 1);
    repeat (50) @(posedge clk);
    #1;

    // Reset mid-sweep restarts the full sweep on both instances
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_clear_busy_d0", 32'(clr_busy[0]), 1);
    check("rst_mid_clear_busy_d1", 32'(clr_busy[1]), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear(c0, c1);
    check("reclear_cycles_d0", c0, DEPTH0);
    check("reclear_cycles_d1", c1, DEPTH1);
    model_clear(0);
    model_clear(1);

    do_req(0, 1'b0, 1'b0, 8'd3,   8'h00, 0);
    do_req(0, 1'b0, 1'b0, 8'd5,   8'h00, 0);
    do_req(0, 1'b0, 1'b0, 8'h10,  8'h00, 0);
    do_req(0, 1'b0, 1'b1, 8'd0,   8'h00, 0);
    do_req(1, 1'b0, 1'b1, 8'd0,   8'h00, 0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty_d0", exp_q0.size(), 0);
    check("scoreboard_empty_d1", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
